// File: rtl/oddr_tx_gearbox_pkg.sv
// Shared definitions for the ODDRE1 transmit gearbox: FSM encoding, counter widths
// and the (beat, phase, lane) -> input-word bit mapping.
package oddr_tx_gearbox_pkg;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_IDLE = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam int unsigned HOLD_W = 4;

  // phase 0 feeds D1 (rising edge), phase 1 feeds D2 (falling edge)
  function automatic int unsigned beat_bit_idx(input int unsigned lanes,
                                               input int unsigned beat,
                                               input int unsigned phase,
                                               input int unsigned lane);
    return (2 * beat + phase) * lanes + lane;
  endfunction

endpackage

// File: rtl/oddr_skid_buf.sv
// One-entry data+last holding buffer in front of the gearbox shift register.
// Ready is registered and only offered when the buffer is empty and the consumer allows it.
module oddr_skid_buf #(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         srst_i,
  input  logic [W-1:0] s_data_i,
  input  logic         s_valid_i,
  input  logic         s_last_i,
  output logic         s_ready_o,
  input  logic         pop_i,
  input  logic         allow_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic         last_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic         last_q, last_d;
  logic         ready_q, ready_d;

  // Capture on handshake, drain on pop; ready follows the post-edge occupancy
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (s_valid_i && ready_q) begin
      valid_d = 1'b1;
      data_d  = s_data_i;
      last_d  = s_last_i;
    end else if (pop_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
    ready_d = !valid_d && allow_i;
  end

  // Buffer state registers
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      ready_q <= ready_d;
    end
  end

  assign s_ready_o = ready_q;
  assign valid_o   = valid_q;
  assign data_o    = data_q;
  assign last_o    = last_q;

endmodule

// File: rtl/oddr_tx_gearbox.sv
// Splits wide words into per-lane (D1,D2) DDR beats for an ODDRE1 bank, sequences the
// ODDRE1 SR release after reset and flags bursts that starve before their last word.
module oddr_tx_gearbox
  import oddr_tx_gearbox_pkg::*;
#(
  parameter int unsigned LANES    = 4,
  parameter logic        IDLE_VAL = 1'b0,
  parameter int unsigned RATIO    = 4,
  parameter int unsigned RST_HOLD = 4
) (
  input  logic                     C,
  input  logic                     SR,
  input  logic [LANES*2*RATIO-1:0] S_DATA,
  input  logic                     S_VALID,
  input  logic                     S_LAST,
  output logic                     S_READY,
  output logic [LANES-1:0]         O_D1,
  output logic [LANES-1:0]         O_D2,
  output logic                     O_SR,
  output logic                     O_ACTIVE,
  output logic                     UNDERRUN,
  input  logic                     CLR_ERR
);

  localparam int unsigned W  = LANES * 2 * RATIO;
  localparam int unsigned BW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [BW-1:0]     LAST_BEAT = BW'(RATIO - 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RST_HOLD);

  if (LANES < 1 || LANES > 32 || RATIO < 2 || RATIO > 16 || RST_HOLD < 1 || RST_HOLD > 15) begin : g_param_check
    $error("oddr_tx_gearbox: parameter out of range");
  end

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [W-1:0]      shift_q, shift_d;
  logic              cur_last_q, cur_last_d;
  logic [LANES-1:0]  d1_q, d1_d, d2_q, d2_d;
  logic              osr_q, osr_d;
  logic              active_q, active_d;
  logic              underrun_q, underrun_d;

  logic              buf_valid_s, buf_last_s;
  logic [W-1:0]      buf_data_s;
  logic              load_s, emit_s, allow_s, underrun_set_s;
  logic [W-1:0]      emit_src_s;
  logic [LANES-1:0]  beat_d1_s, beat_d2_s;

  oddr_skid_buf #(.W(W)) u_skid (
    .clk_i     (C),
    .srst_i    (SR),
    .s_data_i  (S_DATA),
    .s_valid_i (S_VALID),
    .s_last_i  (S_LAST),
    .s_ready_o (S_READY),
    .pop_i     (load_s),
    .allow_i   (allow_s),
    .valid_o   (buf_valid_s),
    .data_o    (buf_data_s),
    .last_o    (buf_last_s)
  );

  // A new word enters the shift register from IDLE or seamlessly after the final beat
  assign load_s     = buf_valid_s && ((state_q == ST_IDLE) || (state_q == ST_RUN && beat_q == LAST_BEAT));
  assign emit_s     = load_s || (state_q == ST_RUN && beat_q != LAST_BEAT);
  assign emit_src_s = load_s ? buf_data_s : shift_q;
  assign allow_s    = (state_d != ST_HOLD);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign beat_d1_s[l] = emit_src_s[beat_bit_idx(LANES, 0, 0, l)];
    assign beat_d2_s[l] = emit_src_s[beat_bit_idx(LANES, 0, 1, l)];
  end

  // FSM state register
  always_ff @(posedge C) begin
    if (SR) begin
      state_q <= ST_HOLD;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HOLD: begin
        if (hold_cnt_q <= HOLD_W'(1)) state_d = ST_IDLE;
        else                          state_d = ST_HOLD;
      end
      ST_IDLE: begin
        if (buf_valid_s) state_d = ST_RUN;
        else             state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (beat_q == LAST_BEAT && !buf_valid_s) state_d = ST_IDLE;
        else                                     state_d = ST_RUN;
      end
      default: state_d = ST_HOLD;
    endcase
  end

  // FSM outputs and datapath next values
  always_comb begin
    hold_cnt_d     = hold_cnt_q;
    beat_d         = beat_q;
    shift_d        = shift_q;
    cur_last_d     = cur_last_q;
    underrun_set_s = 1'b0;
    osr_d          = (state_d == ST_HOLD);
    case (state_q)
      ST_HOLD: begin
        if (hold_cnt_q != '0) hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        else                  hold_cnt_d = '0;
      end
      ST_RUN: begin
        if (beat_q == LAST_BEAT) begin
          underrun_set_s = !buf_valid_s && !cur_last_q;
        end else begin
          beat_d  = beat_q + BW'(1);
          shift_d = shift_q >> (2 * LANES);
        end
      end
      default: hold_cnt_d = hold_cnt_q;
    endcase
    if (load_s) begin
      beat_d     = '0;
      shift_d    = buf_data_s >> (2 * LANES);
      cur_last_d = buf_last_s;
    end else begin
      cur_last_d = cur_last_q;
    end
    if (emit_s) begin
      d1_d     = beat_d1_s;
      d2_d     = beat_d2_s;
      active_d = 1'b1;
    end else begin
      d1_d     = {LANES{IDLE_VAL}};
      d2_d     = {LANES{IDLE_VAL}};
      active_d = 1'b0;
    end
    // A starvation event wins over a simultaneous clear
    if (underrun_set_s)  underrun_d = 1'b1;
    else if (CLR_ERR)    underrun_d = 1'b0;
    else                 underrun_d = underrun_q;
  end

  // Datapath and output registers
  always_ff @(posedge C) begin
    if (SR) begin
      hold_cnt_q <= HOLD_INIT;
      beat_q     <= '0;
      shift_q    <= '0;
      cur_last_q <= 1'b0;
      d1_q       <= {LANES{IDLE_VAL}};
      d2_q       <= {LANES{IDLE_VAL}};
      osr_q      <= 1'b1;
      active_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      beat_q     <= beat_d;
      shift_q    <= shift_d;
      cur_last_q <= cur_last_d;
      d1_q       <= d1_d;
      d2_q       <= d2_d;
      osr_q      <= osr_d;
      active_q   <= active_d;
      underrun_q <= underrun_d;
    end
  end

  assign O_D1     = d1_q;
  assign O_D2     = d2_q;
  assign O_SR     = osr_q;
  assign O_ACTIVE = active_q;
  assign UNDERRUN = underrun_q;

endmodule
